// File: rtl/bus_initiator_if.sv
// Request-side and bus-side signals of the minimum-mode bus initiator.
// The master view belongs to the initiator; the slave view to the requester/bus environment.
interface bus_initiator_if #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 8
);
  logic                 req;
  logic                 req_write;
  logic                 req_iom;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 req_ready;
  logic                 done;
  logic                 timeout;
  logic [DATA_BITS-1:0] rdata;
  logic                 READY;
  logic                 ALE;
  logic                 IOM;
  logic                 RD;
  logic                 WR;
  logic [ADDR_BITS-1:0] Address;

  // Handshake: a request transfers on the CLK rising edge where req && req_ready;
  // req_* fields need only be stable at that edge. done is a one-cycle pulse, and
  // timeout/rdata are meaningful while done is high.
  modport master (
    input  req, req_write, req_iom, req_addr, req_wdata, READY,
    output req_ready, done, timeout, rdata, ALE, IOM, RD, WR, Address
  );

  modport slave (
    output req, req_write, req_iom, req_addr, req_wdata, READY,
    input  req_ready, done, timeout, rdata, ALE, IOM, RD, WR, Address
  );
endinterface

// File: rtl/bus_initiator.sv
// Single-transfer bus master running the T1-T4 (plus TW) cycle of an 8088-style minimum-mode bus.
// Bus strobes are decoded from the state register only; request and READY feed registers alone.
module bus_initiator #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 8,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bus_initiator_if.master      bus,
  inout  wire  [DATA_BITS-1:0] Data,
  output logic [2:0]           o_dbg_state,
  output logic                 o_dbg_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t               r_state;
  logic                 r_write;
  logic                 r_iom;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [DATA_BITS-1:0] r_rdata;
  logic [7:0]           r_wait_cnt;
  logic                 r_timeout;

  state_t               w_state_nxt;
  logic [7:0]           w_wait_cnt_nxt;
  logic                 w_timeout_nxt;
  logic                 w_capture;
  logic                 w_accept;
  logic                 w_req_ready;
  logic                 w_strobe;
  logic                 w_data_oe;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = 1'b0;
    w_capture      = 1'b0;
    w_req_ready    = (r_state == S_IDLE) || (r_state == S_T4);
    w_accept       = bus.req && w_req_ready;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_T1;
      S_T1:   w_state_nxt = S_T2;
      S_T2:   w_state_nxt = S_T3;
      S_T3: begin
        if (bus.READY) begin
          w_state_nxt = S_T4;
          w_capture   = !r_write;
        end else begin
          w_state_nxt    = S_TW;
          w_wait_cnt_nxt = 8'd1;
        end
      end
      S_TW: begin
        if (bus.READY) begin
          w_state_nxt = S_T4;
          w_capture   = !r_write;
        end else if (r_wait_cnt == WAIT_LIMIT) begin
          // Abort: finish the cycle normally but flag it and leave rdata untouched.
          w_state_nxt   = S_T4;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      S_T4:    w_state_nxt = w_accept ? S_T1 : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_iom      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_iom   <= bus.req_iom;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (w_capture) r_rdata <= Data;
    end
  end

  assign w_strobe  = (r_state == S_T2) || (r_state == S_T3) || (r_state == S_TW);
  assign w_data_oe = w_strobe && r_write;

  assign Data          = w_data_oe ? r_wdata : {DATA_BITS{1'bz}};
  assign bus.req_ready = w_req_ready;
  assign bus.done      = (r_state == S_T4);
  assign bus.timeout   = r_timeout;
  assign bus.rdata     = r_rdata;
  assign bus.ALE       = (r_state == S_T1);
  assign bus.IOM       = r_iom;
  assign bus.RD        = !(w_strobe && !r_write);
  assign bus.WR        = !(w_strobe && r_write);
  assign bus.Address   = r_addr;

  assign o_dbg_state   = r_state;
  assign o_dbg_data_oe = w_data_oe;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: vector table of single transfers plus hand-written
// back-to-back and mid-cycle reset sequences against a small memory/I/O responder.
module tb_bus_initiator;

  logic       clk;
  logic       rst_n;
  wire  [7:0] data_bus;
  logic [2:0] dbg_state;
  logic       dbg_oe;

  bus_initiator_if #(.ADDR_BITS(20), .DATA_BITS(8)) bus ();

  bus_initiator #(.ADDR_BITS(20), .DATA_BITS(8), .MAX_WAIT(15)) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .bus          (bus),
    .Data         (data_bus),
    .o_dbg_state  (dbg_state),
    .o_dbg_data_oe(dbg_oe)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- responder model ----------------
  logic [7:0] mem [int];
  int         resp_key;
  logic [7:0] resp_rd;

  function automatic int key_of(input logic iom, input logic [19:0] a);
    return int'({11'd0, iom, a});
  endfunction

  assign data_bus = (bus.RD == 1'b0) ? resp_rd : 8'hzz;

  always @(posedge clk) begin
    if (bus.ALE) begin
      resp_key <= key_of(bus.IOM, bus.Address);
      resp_rd  <= mem.exists(key_of(bus.IOM, bus.Address)) ? mem[key_of(bus.IOM, bus.Address)] : 8'h00;
    end
    if (bus.WR == 1'b0) mem[resp_key] = data_bus;
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    string       tag;
    logic        wr;
    logic        iom;
    logic [19:0] addr;
    logic [7:0]  wdata;
    int          rl;        // cycles READY is held low, starting in T3
    int          exp_done;  // cycle of done, counting T1 as cycle 1
    logic [7:0]  exp_rdata;
    logic        exp_to;
    logic [31:0] exp_ale;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
  } vec_t;

  // ---------------- driver ----------------
  task automatic apply_vec(input vec_t v);
    int          cyc;
    int          done_cyc;
    int          data_err;
    logic [31:0] ale_m, rd_m, wr_m, rr_m;
    logic [19:0] addr_t1;
    logic        iom_t1;
    logic        to_d;
    logic [7:0]  exp_rd;
    bus.req       = 1'b1;
    bus.req_write = v.wr;
    bus.req_iom   = v.iom;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.READY     = 1'b1;
    exp_q.push_back(v.exp_rdata);
    tick();
    bus.req  = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    data_err = 0;
    ale_m = '0; rd_m = '0; wr_m = '0; rr_m = '0;
    addr_t1 = '0; iom_t1 = 1'b0; to_d = 1'b0;
    while (done_cyc < 0 && cyc < 31) begin
      bus.READY = !(cyc >= 3 && cyc < 3 + v.rl);
      if (bus.ALE)       ale_m[cyc] = 1'b1;
      if (!bus.RD)       rd_m[cyc]  = 1'b1;
      if (!bus.WR)       wr_m[cyc]  = 1'b1;
      if (bus.req_ready) rr_m[cyc]  = 1'b1;
      if (cyc == 1) begin
        addr_t1 = bus.Address;
        iom_t1  = bus.IOM;
      end
      if (v.wr && !bus.WR && (!dbg_oe || data_bus !== v.wdata)) data_err++;
      if (bus.done) begin
        done_cyc = cyc;
        to_d     = bus.timeout;
        if (dbg_oe) data_err++;
        exp_rd = exp_q.pop_front();
        check({v.tag, " rdata"}, bus.rdata, exp_rd);
        check({v.tag, " addr_held_t4"}, bus.Address, v.addr);
      end else begin
        tick();
        cyc++;
      end
    end
    check({v.tag, " done_cycle"}, done_cyc, v.exp_done);
    check({v.tag, " timeout"}, to_d, v.exp_to);
    check({v.tag, " ale_cycles"}, ale_m, v.exp_ale);
    check({v.tag, " rd_low_cycles"}, rd_m, v.exp_rd);
    check({v.tag, " wr_low_cycles"}, wr_m, v.exp_wr);
    check({v.tag, " req_ready_cycles"}, rr_m, 32'd1 << v.exp_done);
    check({v.tag, " addr_t1"}, addr_t1, v.addr);
    check({v.tag, " iom_t1"}, iom_t1, v.iom);
    check({v.tag, " data_bus"}, data_err, 0);
    if (v.wr) check({v.tag, " responder_mem"}, mem[key_of(v.iom, v.addr)], v.wdata);
    bus.READY = 1'b1;
    tick();
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];
  vec_t v;

  initial begin
    vecs[0] = '{"rd_mem_0w",  1'b0, 1'b1, 20'h12345, 8'h00, 0,   4,  8'hA5, 1'b0, 32'h2, 32'hC,     32'h0};
    vecs[1] = '{"wr_io_0w",   1'b1, 1'b0, 20'h003F8, 8'h5A, 0,   4,  8'hA5, 1'b0, 32'h2, 32'h0,     32'hC};
    vecs[2] = '{"rd_io_back", 1'b0, 1'b0, 20'h003F8, 8'h00, 0,   4,  8'h5A, 1'b0, 32'h2, 32'hC,     32'h0};
    vecs[3] = '{"rd_mem_3w",  1'b0, 1'b1, 20'h12345, 8'h00, 3,   7,  8'hA5, 1'b0, 32'h2, 32'h7C,    32'h0};
    vecs[4] = '{"rd_timeout", 1'b0, 1'b1, 20'h00777, 8'h00, 100, 19, 8'hA5, 1'b1, 32'h2, 32'h7FFFC, 32'h0};
    vecs[5] = '{"wr_mem_2w",  1'b1, 1'b1, 20'h0FFFF, 8'hC3, 2,   6,  8'hA5, 1'b0, 32'h2, 32'h0,     32'h3C};
    vecs[6] = '{"rd_mem_back",1'b0, 1'b1, 20'h0FFFF, 8'h00, 0,   4,  8'hC3, 1'b0, 32'h2, 32'hC,     32'h0};
    vecs[7] = '{"rd_io_space",1'b0, 1'b0, 20'h12345, 8'h00, 0,   4,  8'h99, 1'b0, 32'h2, 32'hC,     32'h0};

    mem[key_of(1'b1, 20'h12345)] = 8'hA5;
    mem[key_of(1'b1, 20'h00777)] = 8'h3C;
    mem[key_of(1'b0, 20'h12345)] = 8'h99;
    resp_key = 0;
    resp_rd  = 8'h00;

    bus.req = 1'b0; bus.req_write = 1'b0; bus.req_iom = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.READY = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    check("rst state",     dbg_state, 3'd0);
    check("rst ALE",       bus.ALE, 1'b0);
    check("rst RD",        bus.RD, 1'b1);
    check("rst WR",        bus.WR, 1'b1);
    check("rst IOM",       bus.IOM, 1'b0);
    check("rst Address",   bus.Address, 20'h0);
    check("rst done",      bus.done, 1'b0);
    check("rst timeout",   bus.timeout, 1'b0);
    check("rst rdata",     bus.rdata, 8'h00);
    check("rst req_ready", bus.req_ready, 1'b1);
    check("rst data_oe",   dbg_oe, 1'b0);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Back-to-back: write 0x10000<-0x11 then read it with req held high.
    begin
      logic [31:0] ale_m, done_m;
      logic [7:0]  rd_second;
      ale_m = '0; done_m = '0; rd_second = 8'h00;
      bus.req = 1'b1; bus.req_write = 1'b1; bus.req_iom = 1'b1;
      bus.req_addr = 20'h10000; bus.req_wdata = 8'h11; bus.READY = 1'b1;
      tick();
      bus.req_write = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        if (bus.ALE)  ale_m[c]  = 1'b1;
        if (bus.done) done_m[c] = 1'b1;
        if (c == 8)   rd_second = bus.rdata;
        if (c == 4)   check("b2b req_ready_t4", bus.req_ready, 1'b1);
        tick();
        if (c == 4) bus.req = 1'b0;
      end
      check("b2b ale_cycles",  ale_m, 32'h22);
      check("b2b done_cycles", done_m, 32'h110);
      check("b2b rdata",       rd_second, 8'h11);
    end

    // Reset during T2 of a write.
    begin
      int   n_done;
      vec_t wv;
      vec_t rv;
      bus.req = 1'b1; bus.req_write = 1'b1; bus.req_iom = 1'b1;
      bus.req_addr = 20'h00ABC; bus.req_wdata = 8'h77;
      tick();
      bus.req = 1'b0;
      tick();
      check("mid T2 WR",      bus.WR, 1'b0);
      check("mid T2 data_oe", dbg_oe, 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst state",   dbg_state, 3'd0);
      check("arst ALE",     bus.ALE, 1'b0);
      check("arst RD",      bus.RD, 1'b1);
      check("arst WR",      bus.WR, 1'b1);
      check("arst data_oe", dbg_oe, 1'b0);
      check("arst Address", bus.Address, 20'h0);
      check("arst rdata",   bus.rdata, 8'h00);
      n_done = 0;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (bus.done) n_done++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (bus.done) n_done++;
      end
      check("arst no_done", n_done, 0);
      wv = '{"post_rst_wr", 1'b1, 1'b1, 20'h00ABC, 8'h77, 0, 4, 8'h00, 1'b0, 32'h2, 32'h0, 32'hC};
      rv = '{"post_rst_rd", 1'b0, 1'b1, 20'h00ABC, 8'h00, 0, 4, 8'h77, 1'b0, 32'h2, 32'hC, 32'h0};
      apply_vec(wv);
      apply_vec(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
